button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter SIZE, default 8: width of the internal cycle counter in bits.
REQ-002 Parameter STABLE_CYCLES, default 4: number of consecutive equal synchronized samples needed to accept a level change; range 1..2^SIZE-1.
REQ-003 Parameter REPEAT_DELAY, default 16: cycles in HIGH before the first auto-repeat pulse; range 1..2^SIZE-1.
REQ-004 Parameter REPEAT_PERIOD, default 8: cycles between later auto-repeat pulses; range 1..2^SIZE-1.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 btn_in  input  1  raw asynchronous button/switch level.
REQ-008 level_out  output  1  debounced registered level.
REQ-009 pulse_out  output  1  one-cycle registered pulse, intended as the counter's enable.

Function
REQ-010 btn_in SHALL pass through a 2-flop synchronizer; btn_sync is the second flop's output, and only btn_sync feeds the FSM.
REQ-011 FSM states SHALL be LOW, WAIT_HIGH, HIGH and WAIT_LOW, with one shared SIZE-bit counter cnt.
REQ-012 LOW: level_out=0; btn_sync=1 -> WAIT_HIGH with cnt=1; otherwise stay.
REQ-013 WAIT_HIGH: btn_sync=0 -> LOW with no output change; btn_sync=1 and cnt=STABLE_CYCLES -> HIGH; otherwise cnt+1.
REQ-014 For STABLE_CYCLES=1, the single btn_sync=1 sample in LOW SHALL go directly to HIGH.
REQ-015 On entry to HIGH, level_out SHALL go 1 and pulse_out SHALL be 1 for exactly that one cycle.
REQ-016 Latency: with btn_in stable high from clock edge E, pulse_out and level_out SHALL be high after edge E+STABLE_CYCLES+1.
REQ-017 HIGH: btn_sync=0 -> WAIT_LOW with cnt=1; WAIT_LOW is symmetric to WAIT_HIGH.
REQ-018 From WAIT_LOW, STABLE_CYCLES zeros -> LOW with level_out=0 and no pulse.
REQ-019 From WAIT_LOW, a 1 before the count completes -> HIGH with no pulse.
REQ-020 Bounces shorter than STABLE_CYCLES samples SHALL never change level_out or produce a pulse.
REQ-021 cnt SHALL saturate, never wrap; pulse_out SHALL never be high on two consecutive cycles.

Reset
REQ-022 reset=1 at an edge SHALL clear both synchronizer flops, cnt and the repeat timer, set state LOW, level_out=0 and pulse_out=0.
REQ-023 Reset SHALL take priority over all other activity in any state, including mid-debounce or mid-repeat.
REQ-024 After reset deasserts, a btn_in already held high SHALL be treated as a new press, with full REQ-016 latency and one pulse.

Configuration
REQ-025 Macro BUTTON_DEBOUNCER_AUTO_REPEAT_EN SHALL control auto-repeat.
REQ-026 With the macro defined, a repeat timer SHALL count cycles in HIGH, starting at 0 on each HIGH entry.
REQ-027 With the macro defined, pulse_out SHALL be 1 for one cycle REPEAT_DELAY cycles after the entry pulse, then every REPEAT_PERIOD cycles while in HIGH.
REQ-028 With the macro defined, leaving HIGH SHALL stop repeats; a return from WAIT_LOW SHALL restart REPEAT_DELAY.
REQ-029 With the macro undefined, the repeat timer SHALL not exist and each accepted press SHALL give exactly one pulse.

Verification
REQ-030 Clean press (STABLE_CYCLES=4): btn_in 0->1 before edge 0, held -> pulse_out high only after edge 5, level_out high from edge 5.
REQ-031 Bounce: btn_in high for 3 edges, low for 1, high for 2, then low -> level_out and pulse_out stay 0 throughout.
REQ-032 Release glitch: held press, then btn_in low for 2 edges and high again -> level_out stays 1, no extra pulse; a full 4-edge low -> level_out=0.
REQ-033 Reset mid-debounce: reset=1 during WAIT_HIGH with btn_in held, then released -> outputs 0 during reset; pulse after edge 5 counted from the first edge with reset=0.
REQ-034 Auto-repeat on (16/8): hold 40 cycles after acceptance -> pulses at offsets 0, 16, 24, 32, 40; with the macro off -> only offset 0.
REQ-035 Counter chain: pulse_out drives the counter's enable (SIZE=4, MAX_VALUE=10); 11 clean presses -> counter reads 0.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw button level in, debounced level and
// one-cycle press pulse out. Clock and reset stay plain ports on the module.
interface button_debouncer_if;
    logic btn_in;
    logic level_out;
    logic pulse_out;

    modport master (
        output btn_in,
        input  level_out,
        input  pulse_out
    );

    modport slave (
        input  btn_in,
        output level_out,
        output pulse_out
    );
endinterface

// File: rtl/button_debouncer.sv
// Debounces a raw button through a 2-flop synchronizer and a LOW/WAIT_HIGH/HIGH/WAIT_LOW FSM.
// Define BUTTON_DEBOUNCER_AUTO_REPEAT_EN to add auto-repeat pulses while the button is held.
module button_debouncer #(
    parameter int SIZE          = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic               clk,
    input  logic               reset,
    button_debouncer_if.slave  bus
);

    localparam logic [1:0] ST_LOW       = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
    localparam logic [1:0] ST_HIGH      = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    // The sample that leaves LOW/HIGH is the first of the STABLE_CYCLES run,
    // so the wait states finish once cnt reaches STABLE_CYCLES-1.
    localparam logic [SIZE-1:0] LAST_CNT = SIZE'(STABLE_CYCLES - 1);
    localparam bit              SINGLE   = (STABLE_CYCLES == 1);

    logic            sync1_q, sync2_q;
    logic            btn_sync;
    logic [1:0]      state_q, state_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            pulse_q, pulse_d;
    logic            pulse_entry;
    logic            enter_high;
    logic            rpt_fire;

    assign btn_sync = sync2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        pulse_entry = 1'b0;
        enter_high  = 1'b0;
        case (state_q)
            ST_LOW: begin
                level_d = 1'b0;
                if (btn_sync) begin
                    if (SINGLE) begin
                        state_d     = ST_HIGH;
                        level_d     = 1'b1;
                        pulse_entry = 1'b1;
                        enter_high  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                        cnt_d   = SIZE'(1);
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (!btn_sync) begin
                    state_d = ST_LOW;
                end else if (cnt_q >= LAST_CNT) begin
                    state_d     = ST_HIGH;
                    level_d     = 1'b1;
                    pulse_entry = 1'b1;
                    enter_high  = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                level_d = 1'b1;
                if (!btn_sync) begin
                    if (SINGLE) begin
                        state_d = ST_LOW;
                        level_d = 1'b0;
                    end else begin
                        state_d = ST_WAIT_LOW;
                        cnt_d   = SIZE'(1);
                    end
                end
            end
            ST_WAIT_LOW: begin
                if (btn_sync) begin
                    // Glitch on release: back to HIGH silently, repeat timing restarts.
                    state_d    = ST_HIGH;
                    enter_high = 1'b1;
                end else if (cnt_q >= LAST_CNT) begin
                    state_d = ST_LOW;
                    level_d = 1'b0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LOW;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
    localparam logic [SIZE-1:0] DELAY_LIM  = SIZE'(REPEAT_DELAY);
    localparam logic [SIZE-1:0] PERIOD_LIM = SIZE'(REPEAT_PERIOD);

    logic [SIZE-1:0] rpt_q, rpt_d;
    logic [SIZE-1:0] rpt_inc;
    logic [SIZE-1:0] rpt_lim;
    logic            rpt_first_q, rpt_first_d;

    assign rpt_inc = rpt_q + 1'b1;
    assign rpt_lim = rpt_first_q ? DELAY_LIM : PERIOD_LIM;

    always_comb begin
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
        rpt_fire    = 1'b0;
        if (enter_high) begin
            rpt_d       = '0;
            rpt_first_d = 1'b1;
        end else if (state_q == ST_HIGH && state_d == ST_HIGH) begin
            if (rpt_inc == rpt_lim) begin
                // Hold off one cycle rather than emit back-to-back pulses.
                if (!pulse_q) begin
                    rpt_fire    = 1'b1;
                    rpt_d       = '0;
                    rpt_first_d = 1'b0;
                end
            end else begin
                rpt_d = rpt_inc;
            end
        end else begin
            rpt_d       = '0;
            rpt_first_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    logic unused_repeat_cfg;

    assign rpt_fire          = 1'b0;
    // Repeat parameters and HIGH-entry strobe only matter with auto-repeat built in.
    assign unused_repeat_cfg = ^{enter_high, SIZE'(REPEAT_DELAY), SIZE'(REPEAT_PERIOD)};
`endif

    assign pulse_d = pulse_entry | rpt_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= bus.btn_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.level_out = level_q;
    assign bus.pulse_out = pulse_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: press latency, bounce rejection, release glitch,
// reset priority, auto-repeat timing (BUTTON_DEBOUNCER_AUTO_REPEAT_EN) and a pulse-driven counter.
module tb_button_debouncer;

    localparam int RD = 16;
    localparam int RP = 8;
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [3:0] ccnt;

    button_debouncer_if bus ();

    button_debouncer #(
        .SIZE         (8),
        .STABLE_CYCLES(4),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream counter enabled by pulse_out, wraps after MAX_VALUE=10.
    always @(posedge clk) begin
        if (reset)
            ccnt <= 4'd0;
        else if (bus.pulse_out)
            ccnt <= (ccnt == 4'd10) ? 4'd0 : ccnt + 4'd1;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive btn before the next edge, then check both outputs just after it.
    task automatic step(input logic b, input logic el, input logic ep, input string tag);
        bus.btn_in = b;
        @(posedge clk);
        #1;
        $display("step %-14s btn=%0b level=%0b pulse=%0b", tag, b, bus.level_out, bus.pulse_out);
        check({tag, "_level"}, {7'd0, bus.level_out}, {7'd0, el});
        check({tag, "_pulse"}, {7'd0, bus.pulse_out}, {7'd0, ep});
    endtask

    task automatic press_accept(input string tag);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, {tag, "_wait"});
        step(1'b1, 1'b1, 1'b1, {tag, "_accept"});
    endtask

    task automatic release_btn(input string tag);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, {tag, "_rel"});
        step(1'b0, 1'b0, 1'b0, {tag, "_low"});
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b1;
        bus.btn_in = 1'b0;

        step(1'b0, 1'b0, 1'b0, "reset");
        step(1'b0, 1'b0, 1'b0, "reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "idle");

        // Clean press: high from edge 5, single pulse.
        press_accept("clean");
        step(1'b1, 1'b1, 1'b0, "clean_hold");
        release_btn("clean");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, "idle");

        // Bounce: 3 high, 1 low, 2 high, then low -- never accepted.
        step(1'b1, 1'b0, 1'b0, "bounce");
        step(1'b1, 1'b0, 1'b0, "bounce");
        step(1'b1, 1'b0, 1'b0, "bounce");
        step(1'b0, 1'b0, 1'b0, "bounce");
        step(1'b1, 1'b0, 1'b0, "bounce");
        step(1'b1, 1'b0, 1'b0, "bounce");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, "bounce");

        // Release glitch: 2 low edges while held keep level high, no extra pulse.
        press_accept("glitch");
        step(1'b1, 1'b1, 1'b0, "glitch_hold");
        step(1'b1, 1'b1, 1'b0, "glitch_hold");
        step(1'b0, 1'b1, 1'b0, "glitch_lo");
        step(1'b0, 1'b1, 1'b0, "glitch_lo");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, "glitch_back");
        release_btn("glitch");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, "idle");

        // Reset mid-debounce with button held: full latency again afterwards.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "rstmid_pre");
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, "rstmid_in");
        step(1'b1, 1'b0, 1'b0, "rstmid_in");
        reset = 1'b0;
        press_accept("rstmid");
        step(1'b1, 1'b1, 1'b0, "rstmid_hold");
        release_btn("rstmid");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, "idle");

        // Hold 40 cycles after acceptance: repeats at offsets 16, 24, 32, 40 when enabled.
        press_accept("repeat");
        for (int k = 1; k <= 40; k++)
            step(1'b1, 1'b1, RPT_EN && (k >= RD) && (((k - RD) % RP) == 0), "repeat_hold");
        release_btn("repeat");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, "idle");

        // Reset on the very cycle a repeat would fire takes priority.
        press_accept("rstrpt");
        for (int k = 1; k < RD; k++) step(1'b1, 1'b1, 1'b0, "rstrpt_hold");
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, "rstrpt_in");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "rstrpt_idle");

        // Counter chain: 11 presses wrap a 0..10 counter back to 0.
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, "chain_rst");
        reset = 1'b0;
        check("chain_init", {4'd0, ccnt}, 8'd0);
        for (int p = 1; p <= 11; p++) begin
            press_accept("chain");
            step(1'b1, 1'b1, 1'b0, "chain_hold");
            release_btn("chain");
            step(1'b0, 1'b0, 1'b0, "chain_idle");
            $display("chain press %0d counter=%0d", p, ccnt);
            check("chain_cnt", {4'd0, ccnt}, 8'(p % 11));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
